// File: rtl/fifo_rd_arbiter_pkg.sv
// fifo_rd_arbiter_pkg: shared FSM encoding, burst-length limits and index helper for the read arbiter
//  MAX_LEN : longest burst any requester may ask for
//  IDX_W   : width of the burst word counter / rd_idx
package fifo_rd_arbiter_pkg;
  localparam int MAX_LEN = 15;
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  typedef enum logic [1:0] {IDLE, BURST, LAST} state_t;
  function automatic logic [IDX_W-1:0] last_idx(input int len);
    return IDX_W'(len - 1);
  endfunction
endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: requester, FIFO and result signals of the read arbiter
//  master: drives req0/req1/clr_ovf, fifo_level, fifo_rdata; observes the rest
//  slave : the arbiter side (fifo_rd, rd_data, rd_valid0/1, rd_idx, done0/1, busy, ovf0/1)
interface fifo_rd_arbiter_if #(parameter int DW = 32, parameter int LVLW = 9);
  logic req0;
  logic req1;
  logic clr_ovf;
  logic [LVLW-1:0] fifo_level;
  logic fifo_rd;
  logic [DW-1:0] fifo_rdata;
  logic [DW-1:0] rd_data;
  logic rd_valid0;
  logic rd_valid1;
  logic [fifo_rd_arbiter_pkg::IDX_W-1:0] rd_idx;
  logic done0;
  logic done1;
  logic busy;
  logic ovf0;
  logic ovf1;
  modport master (
    output req0, req1, clr_ovf, fifo_level, fifo_rdata,
    input  fifo_rd, rd_data, rd_valid0, rd_valid1, rd_idx, done0, done1, busy, ovf0, ovf1
  );
  modport slave (
    input  req0, req1, clr_ovf, fifo_level, fifo_rdata,
    output fifo_rd, rd_data, rd_valid0, rd_valid1, rd_idx, done0, done1, busy, ovf0, ovf1
  );
endinterface

// File: rtl/fifo_rd_arbiter_req_latch.sv
// fifo_rd_arbiter_req_latch: per-requester pending bit and sticky overflow flag
//  req in 1-cycle request pulse; grant in winner-select cycle; clr_ovf in clears ovf
//  pend out request waiting for a grant; ovf out sticky, a pulse arrived while already pending
module fifo_rd_arbiter_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic grant,
  input  logic clr_ovf,
  output logic pend,
  output logic ovf
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      ovf <= 1'b0;
    end else begin
      pend <= grant ? req : pend | req;
      // a fresh overflow wins over a simultaneous clear
      ovf <= (req & pend & ~grant) | (ovf & ~clr_ovf);
    end
  end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares one no-show-ahead FIFO read port between two burst requesters
//  clk, rst_n : clock, asynchronous active-low reset
//  bus.slave  : req0/req1/clr_ovf/fifo_level/fifo_rdata in;
//               fifo_rd/rd_data/rd_valid0/1/rd_idx/done0/1/busy/ovf0/1 out
module fifo_rd_arbiter import fifo_rd_arbiter_pkg::*; #(
  parameter int DW = 32,
  parameter int LEN0 = 3,
  parameter int LEN1 = 1,
  parameter int LVLW = 9,
  parameter bit RR = 1'b1
) (
  input logic clk,
  input logic rst_n,
  fifo_rd_arbiter_if.slave bus
);
  state_t state;
  logic gnt;
  logic last_grant;
  logic rd_q;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_cnt;
  logic pend0;
  logic pend1;
  logic el0;
  logic el1;
  logic win;
  logic go;
  // a requester only qualifies once the FIFO already holds its whole burst
  assign el0 = pend0 && (bus.fifo_level >= LVLW'(LEN0));
  assign el1 = pend1 && (bus.fifo_level >= LVLW'(LEN1));
  // round-robin only matters on a tie; a lone eligible requester is never blocked
  assign win = RR ? ((el0 && el1) ? ~last_grant : el1) : ~el0;
  assign go = (state == IDLE) && (el0 || el1);
  assign last_cnt = gnt ? last_idx(LEN1) : last_idx(LEN0);
  fifo_rd_arbiter_req_latch u_lat0 (
    .clk(clk), .rst_n(rst_n), .req(bus.req0), .grant(go && !win),
    .clr_ovf(bus.clr_ovf), .pend(pend0), .ovf(bus.ovf0)
  );
  fifo_rd_arbiter_req_latch u_lat1 (
    .clk(clk), .rst_n(rst_n), .req(bus.req1), .grant(go && win),
    .clr_ovf(bus.clr_ovf), .pend(pend1), .ovf(bus.ovf1)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      idx_q <= '0;
      rd_q <= 1'b0;
      bus.fifo_rd <= 1'b0;
      bus.busy <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
    end else begin
      rd_q <= bus.fifo_rd;
      idx_q <= cnt;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: if (go) begin
          gnt <= win;
          last_grant <= win;
          bus.busy <= 1'b1;
          bus.fifo_rd <= 1'b1;
          cnt <= '0;
          state <= BURST;
        end
        BURST: if (cnt == last_cnt) begin
          // done is registered here so it lines up with the final data word
          bus.fifo_rd <= 1'b0;
          bus.done0 <= ~gnt;
          bus.done1 <= gnt;
          state <= LAST;
        end else begin
          cnt <= cnt + 1'b1;
        end
        LAST: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.rd_data = DW'(bus.fifo_rdata);
  assign bus.rd_valid0 = rd_q & ~gnt;
  assign bus.rd_valid1 = rd_q & gnt;
  assign bus.rd_idx = idx_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: scoreboard bench with a FIFO model feeding fifo_level/fifo_rdata
module tb_fifo_rd_arbiter;
  localparam int DW = 32;
  localparam int LVLW = 9;
  typedef struct packed {
    logic who;
    logic [3:0] idx;
    logic [31:0] data;
    logic done;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fifo_rd_arbiter_if #(.DW(DW), .LVLW(LVLW)) bus ();
  fifo_rd_arbiter #(.DW(DW), .LEN0(3), .LEN1(1), .LVLW(LVLW), .RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  exp_t sb[$];
  logic [31:0] fq[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  int wctr = 0;
  int rdctr = 0;
  logic rd_s = 1'b0;
  // FIFO model: data appears one cycle after fifo_rd, level tracks contents
  always @(negedge clk) rd_s = bus.fifo_rd;
  always @(posedge clk) begin
    #1;
    if (rd_s) begin
      tests++;
      if (fq.size() == 0) begin
        fails++;
        $display("FAIL fifo_underflow: fifo_rd=1 with level 0, required no read");
      end else begin
        bus.fifo_rdata = fq.pop_front();
      end
    end
    bus.fifo_level = LVLW'(fq.size());
  end
  // scoreboard: each valid word must match the next expected word
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid0 || bus.rd_valid1) begin
        tests++;
        if (bus.rd_valid0 && bus.rd_valid1) begin
          fails++;
          $display("FAIL both_valid: rd_valid0=1 rd_valid1=1, required one-hot");
        end else if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: valid%0d idx=%0d data=%h, required no output", bus.rd_valid1, bus.rd_idx, bus.rd_data);
        end else begin
          e = sb.pop_front();
          if ({bus.rd_valid1, bus.rd_idx, bus.rd_data, bus.done1, bus.done0} !==
              {e.who, e.idx, e.data, e.done & e.who, e.done & ~e.who}) begin
            fails++;
            $display("FAIL sb_word: got who=%0d idx=%0d data=%h done1/0=%b%b, required who=%0d idx=%0d data=%h done=%0d",
              bus.rd_valid1, bus.rd_idx, bus.rd_data, bus.done1, bus.done0, e.who, e.idx, e.data, e.done);
          end
        end
      end else if (bus.done0 || bus.done1) begin
        tests++;
        fails++;
        $display("FAIL done_no_valid: done1/0=%b%b without rd_valid, required 00", bus.done1, bus.done0);
      end
    end
  end
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(32'hA000_0000 + 32'(wctr));
      wctr++;
    end
  endtask
  task automatic exp_burst(input logic who, input int len);
    exp_t x;
    for (int i = 0; i < len; i++) begin
      x.who = who;
      x.idx = 4'(i);
      x.data = 32'hA000_0000 + 32'(rdctr);
      x.done = (i == len - 1);
      sb.push_back(x);
      rdctr++;
    end
  endtask
  task automatic pulse(input logic r0, input logic r1);
    @(negedge clk);
    bus.req0 = r0;
    bus.req1 = r1;
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask
  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || bus.fifo_rd) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0 || bus.busy) begin
      fails++;
      $display("FAIL %s_timeout: %0d words outstanding busy=%0d after %0d cycles, required 0", name, sb.size(), bus.busy, budget);
    end
  endtask
  task automatic quiet(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= bus.fifo_rd;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL %s_no_read: fifo_rd=%0d seen, required 0", name, seen);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    fq.delete();
    sb.delete();
    rdctr = wctr;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (bus.fifo_rd !== 1'b0) begin
      fails++;
      $display("FAIL reset_fifo_rd: got %b, required 0", bus.fifo_rd);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b, required 0", bus.busy);
    end
    tests++;
    if ({bus.rd_valid0, bus.rd_valid1, bus.done0, bus.done1, bus.rd_idx} !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid/done/idx got %b, required 0", {bus.rd_valid0, bus.rd_valid1, bus.done0, bus.done1, bus.rd_idx});
    end
    tests++;
    if ({bus.ovf0, bus.ovf1} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ovf: got %b, required 00", {bus.ovf0, bus.ovf1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single();
    push_words(3);
    repeat (3) @(negedge clk);
    exp_burst(1'b0, 3);
    bus.req0 = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b0;
    tests++;
    if (bus.fifo_rd !== 1'b0) begin
      fails++;
      $display("FAIL single_grant_cycle: fifo_rd=%b, required 0", bus.fifo_rd);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.fifo_rd, bus.busy} !== 2'b11) begin
        fails++;
        $display("FAIL single_read%0d: fifo_rd/busy=%b, required 11", i, {bus.fifo_rd, bus.busy});
      end
    end
    @(negedge clk);
    tests++;
    if ({bus.fifo_rd, bus.done0, bus.busy} !== 3'b011) begin
      fails++;
      $display("FAIL single_done: fifo_rd/done0/busy=%b, required 011", {bus.fifo_rd, bus.done0, bus.busy});
    end
    @(negedge clk);
    tests++;
    if ({bus.done0, bus.busy} !== 2'b00) begin
      fails++;
      $display("FAIL single_release: done0/busy=%b, required 00", {bus.done0, bus.busy});
    end
    wait_idle("single", 20);
  endtask
  task automatic test_level_wait();
    push_words(2);
    repeat (2) @(negedge clk);
    exp_burst(1'b0, 3);
    pulse(1'b1, 1'b0);
    quiet("level_wait", 10);
    push_words(1);
    wait_idle("level_wait", 30);
  endtask
  task automatic test_rr();
    do_reset();
    push_words(11);
    repeat (2) @(negedge clk);
    exp_burst(1'b0, 3);
    exp_burst(1'b1, 1);
    pulse(1'b1, 1'b1);
    wait_idle("rr_tie0", 40);
    exp_burst(1'b0, 3);
    pulse(1'b1, 1'b0);
    wait_idle("rr_solo0", 40);
    exp_burst(1'b1, 1);
    exp_burst(1'b0, 3);
    pulse(1'b1, 1'b1);
    wait_idle("rr_tie1", 40);
  endtask
  task automatic test_starve();
    do_reset();
    push_words(2);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0);
    quiet("starve_wait0", 5);
    exp_burst(1'b1, 1);
    pulse(1'b0, 1'b1);
    wait_idle("starve_burst1", 30);
    quiet("starve_hold0", 4);
    exp_burst(1'b0, 3);
    push_words(2);
    wait_idle("starve_burst0", 30);
  endtask
  task automatic test_ovf();
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    tests++;
    if ({bus.ovf0, bus.ovf1} !== 2'b01) begin
      fails++;
      $display("FAIL ovf_set: ovf0/ovf1=%b, required 01", {bus.ovf0, bus.ovf1});
    end
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    tests++;
    if (bus.ovf1 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf1=%b, required 0", bus.ovf1);
    end
    push_words(1);
    exp_burst(1'b1, 1);
    exp_burst(1'b1, 1);
    @(negedge clk);
    bus.req1 = 1'b1;
    @(negedge clk);
    bus.req1 = 1'b0;
    tests++;
    if (bus.fifo_rd !== 1'b1) begin
      fails++;
      $display("FAIL ovf_grant_timing: fifo_rd=%b, required 1", bus.fifo_rd);
    end
    push_words(1);
    wait_idle("ovf_rearm", 30);
    tests++;
    if (bus.ovf1 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_grant_req: ovf1=%b, required 0", bus.ovf1);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    push_words(3);
    repeat (2) @(negedge clk);
    exp_burst(1'b0, 3);
    pulse(1'b1, 1'b0);
    while (!bus.fifo_rd && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.fifo_rd, bus.rd_valid0, bus.done0, bus.busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid: fifo_rd/valid0/done0/busy=%b, required 0000", {bus.fifo_rd, bus.rd_valid0, bus.done0, bus.busy});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    fq.delete();
    rdctr = wctr;
    rst_n = 1'b1;
    push_words(3);
    quiet("reset_mid_idle", 10);
    exp_burst(1'b0, 3);
    pulse(1'b1, 1'b0);
    wait_idle("reset_mid_after", 30);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.fifo_rdata = '0;
    bus.fifo_level = '0;
    test_reset();
    test_single();
    test_level_wait();
    test_rr();
    test_starve();
    test_ovf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
